// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage pipeline register for the pipelined MIPS core. It
//   carries a packed datapath bundle and a packed control bundle between two
//   stages. Flow control is valid/ready, and a two-entry skid buffer lets
//   in_ready come straight from a flop. A synchronous flush squashes every
//   held entry and inserts a bubble. All state changes on the falling edge
//   of clk.
//
//   Ports
//     clk        clock (falling-edge active)
//     reset      asynchronous, active-low reset
//     flush      synchronous squash of all held entries
//     in_valid   upstream entry valid
//     in_ready   stage can accept an entry (registered)
//     in_data    upstream datapath bundle, word 0 in the LSBs
//     in_ctrl    upstream control bundle
//     out_valid  downstream entry valid (registered)
//     out_ready  downstream accepts
//     out_data   held datapath bundle
//     out_ctrl   held control bundle, forced to zero on a bubble
//
//   Optional build macro PIPE_STAGE_STATS_EN adds the outputs stall_cycles
//   and bubble_cycles (32-bit wrapping event counters).
//
//   state | meaning
//   ------+---------------------------------------------------
//   EMPTY | nothing held; out_valid=0, in_ready=1
//   ONE   | main entry presented, skid free; in_ready=1
//   FULL  | main presented and skid occupied; in_ready=0
module pipe_stage_reg #(
  parameter int DATA_W         = 32,
  parameter int NUM_WORDS      = 6,
  parameter int CTRL_W         = 16,
  parameter int FLUSH_CLR_DATA = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_WORDS*DATA_W-1:0]   in_data,
  input  logic [CTRL_W-1:0]             in_ctrl,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_WORDS*DATA_W-1:0]   out_data,
  output logic [CTRL_W-1:0]             out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   bubble_cycles
`endif
);

  localparam int BUS_W = NUM_WORDS * DATA_W;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BUS_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [BUS_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // An out_fire in this cycle was already seen downstream; an in_fire is dropped.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (FLUSH_CLR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            // Downstream stalled: park the newcomer behind the presented entry.
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      // Handshake outputs are decoded from the next state so both leave a flop.
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  // Bubble guarantee: no stray RegWrite/MemWrite/Branch leaks out on an empty slot.
  assign out_ctrl  = out_valid_q ? main_ctrl_q : '0;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid_q && !out_ready) begin
        stall_q <= stall_q + 32'd1;
      end
      if (!out_valid_q || flush) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`endif

endmodule
